lcd_power_sequencer: RTL and testbench

Sequences panel power, LVDS video enable and backlight for the 1366x768 LVDS LCD in the pixel-clock domain. It sits between the top-level control (request, brightness, MMCM lock) and the panel pins and timing generator. It enforces minimum panel power-up and power-down intervals and aborts cleanly on request drop or lost clock lock. It also generates the backlight PWM.

---
 rtl/lcd_power_sequencer.sv | 185 ++++++++++++++++++
 tb/tb_lcd_power_sequencer.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/lcd_power_sequencer.sv
// lcd_power_sequencer
// Sequences panel VDD, LVDS video enable and the backlight for the LVDS LCD,
// all in the pixel-clock domain. It enforces minimum on/off intervals, aborts
// cleanly when the request drops, and flags a sticky fault if lock is lost while
// the backlight is on. A free-running prescaler and step counter generate the
// backlight PWM. The duty value is latched only at period boundaries.
module lcd_power_sequencer #(
  parameter int T_VDD    = 720000,
  parameter int T_VID    = 14400000,
  parameter int T_BLOFF  = 14400000,
  parameter int T_VIDOFF = 720000,
  parameter int T_OFF    = 36000000,
  parameter int PWM_DIV  = 14
) (
  input  logic       pixel_clk,
  input  logic       rst,
  input  logic       panel_req,
  input  logic       pll_locked,
  input  logic [7:0] brightness,
  output logic       panel_vdd_en,
  output logic       video_en,
  output logic       led_en,
  output logic       led_pwm,
  output logic       panel_ready,
  output logic       fault,
  output logic [2:0] state
);

  localparam logic [2:0] ST_OFF       = 3'd0;
  localparam logic [2:0] ST_VDD_UP    = 3'd1;
  localparam logic [2:0] ST_LINK_UP   = 3'd2;
  localparam logic [2:0] ST_BL_ON     = 3'd3;
  localparam logic [2:0] ST_BL_DOWN   = 3'd4;
  localparam logic [2:0] ST_LINK_DOWN = 3'd5;
  localparam logic [2:0] ST_OFF_WAIT  = 3'd6;

  // A prescaler of a single step still needs a 1-bit register.
  localparam int PW = (PWM_DIV > 1) ? $clog2(PWM_DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(PWM_DIV - 1);

  logic [2:0]    r_state;
  logic [2:0]    w_state_next;
  logic [25:0]   r_cnt;
  logic [25:0]   w_cnt_next;
  logic          r_fault;
  logic          w_fault_next;
  logic          w_cnt_zero;

  logic [PW-1:0] r_presc;
  logic [7:0]    r_pcnt;
  logic [7:0]    r_duty;
  logic          r_led_pwm;

  assign w_cnt_zero = (r_cnt == 26'd0);

  // Load value for the interval counter when a timed state is entered (T-1).
  function automatic logic [25:0] f_load(input logic [2:0] s);
    case (s)
      ST_VDD_UP:    f_load = 26'(T_VDD - 1);
      ST_LINK_UP:   f_load = 26'(T_VID - 1);
      ST_BL_DOWN:   f_load = 26'(T_BLOFF - 1);
      ST_LINK_DOWN: f_load = 26'(T_VIDOFF - 1);
      ST_OFF_WAIT:  f_load = 26'(T_OFF - 1);
      default:      f_load = 26'd0;
    endcase
  endfunction

  // State, interval counter and sticky fault registers.
  always_ff @(posedge pixel_clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_OFF;
      r_cnt   <= 26'd0;
      r_fault <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
      r_fault <= w_fault_next;
    end
  end

  // Next-state, counter and fault decisions.
  always_comb begin
    w_state_next = r_state;
    w_fault_next = r_fault;
    case (r_state)
      ST_OFF: begin
        if (panel_req) w_state_next = ST_VDD_UP;
      end
      ST_VDD_UP: begin
        // An abort drops VDD on the very next cycle but still honours T_OFF.
        if (!panel_req)      w_state_next = ST_OFF_WAIT;
        else if (w_cnt_zero) w_state_next = ST_LINK_UP;
      end
      ST_LINK_UP: begin
        if (!panel_req)                    w_state_next = ST_LINK_DOWN;
        else if (w_cnt_zero && pll_locked) w_state_next = ST_BL_ON;
      end
      ST_BL_ON: begin
        if (!panel_req || !pll_locked) w_state_next = ST_BL_DOWN;
        if (!pll_locked)               w_fault_next = 1'b1;
      end
      ST_BL_DOWN: begin
        // The request is ignored here: once started, power-down completes.
        if (w_cnt_zero) w_state_next = ST_LINK_DOWN;
      end
      ST_LINK_DOWN: begin
        if (w_cnt_zero) w_state_next = ST_OFF_WAIT;
      end
      ST_OFF_WAIT: begin
        if (w_cnt_zero) w_state_next = ST_OFF;
      end
      default: w_state_next = ST_OFF;
    endcase

    // A fresh power-up attempt clears the previous fault.
    if ((w_state_next == ST_VDD_UP) && (r_state != ST_VDD_UP)) w_fault_next = 1'b0;

    // Load on state entry; hold T_VID at full value while unlocked, so the
    // video-valid interval is measured from the last lock rise.
    if (w_state_next != r_state)
      w_cnt_next = f_load(w_state_next);
    else if ((r_state == ST_LINK_UP) && !pll_locked)
      w_cnt_next = 26'(T_VID - 1);
    else if (!w_cnt_zero)
      w_cnt_next = r_cnt - 26'd1;
    else
      w_cnt_next = r_cnt;
  end

  // Output decode straight from the state register.
  always_comb begin
    panel_vdd_en = 1'b0;
    video_en     = 1'b0;
    led_en       = 1'b0;
    panel_ready  = 1'b0;
    case (r_state)
      ST_VDD_UP: begin
        panel_vdd_en = 1'b1;
      end
      ST_LINK_UP, ST_BL_DOWN: begin
        panel_vdd_en = 1'b1;
        video_en     = 1'b1;
      end
      ST_BL_ON: begin
        panel_vdd_en = 1'b1;
        video_en     = 1'b1;
        led_en       = 1'b1;
        panel_ready  = 1'b1;
      end
      ST_LINK_DOWN: begin
        panel_vdd_en = 1'b1;
      end
      default: ;
    endcase
  end

  // Free-running PWM timebase; duty is latched only at the period start.
  always_ff @(posedge pixel_clk or posedge rst) begin
    if (rst) begin
      r_presc <= '0;
      r_pcnt  <= 8'd0;
      r_duty  <= 8'd0;
    end else begin
      if (r_presc == PRESC_LAST) begin
        r_presc <= '0;
        r_pcnt  <= r_pcnt + 8'd1;
      end else begin
        r_presc <= r_presc + PW'(1);
      end
      if ((r_presc == '0) && (r_pcnt == 8'd0)) r_duty <= brightness;
    end
  end

  // PWM output register, gated by the upcoming led_en so the pin never glows
  // outside the backlight-on state.
  always_ff @(posedge pixel_clk or posedge rst) begin
    if (rst) r_led_pwm <= 1'b0;
    else     r_led_pwm <= (w_state_next == ST_BL_ON) && (r_pcnt < r_duty);
  end

  assign led_pwm = r_led_pwm;
  assign fault   = r_fault;
  assign state   = r_state;

endmodule

// File: tb/tb_lcd_power_sequencer.sv
// Testbench for lcd_power_sequencer: directed sequences followed by random
// request/lock/brightness segments, every cycle compared with a timing model.
module tb_lcd_power_sequencer;

  localparam int T_VDD    = 4;
  localparam int T_VID    = 6;
  localparam int T_BLOFF  = 3;
  localparam int T_VIDOFF = 2;
  localparam int T_OFF    = 5;
  localparam int PWM_DIV  = 1;

  logic       clk;
  logic       rst;
  logic       panel_req;
  logic       pll_locked;
  logic [7:0] brightness;
  logic       panel_vdd_en;
  logic       video_en;
  logic       led_en;
  logic       led_pwm;
  logic       panel_ready;
  logic       fault;
  logic [2:0] state;

  lcd_power_sequencer #(
    .T_VDD(T_VDD), .T_VID(T_VID), .T_BLOFF(T_BLOFF),
    .T_VIDOFF(T_VIDOFF), .T_OFF(T_OFF), .PWM_DIV(PWM_DIV)
  ) dut (
    .pixel_clk   (clk),
    .rst         (rst),
    .panel_req   (panel_req),
    .pll_locked  (pll_locked),
    .brightness  (brightness),
    .panel_vdd_en(panel_vdd_en),
    .video_en    (video_en),
    .led_en      (led_en),
    .led_pwm     (led_pwm),
    .panel_ready (panel_ready),
    .fault       (fault),
    .state       (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int seg   = 0;

  // Reference model: phase (spec encoding), cycles spent in the phase,
  // consecutive locked cycles in the link-up phase, fault flag, and the
  // PWM duty derived from the number of edges since reset release.
  int m_phase, m_t, m_run, m_fault, m_duty, m_edge, m_pwm;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      if (n_err <= 40)
        $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_phase = 0; m_t = 0; m_run = 0; m_fault = 0;
    m_duty = 0; m_edge = 0; m_pwm = 0;
  endtask

  function automatic int dur(input int ph);
    case (ph)
      1: dur = T_VDD;
      4: dur = T_BLOFF;
      5: dur = T_VIDOFF;
      6: dur = T_OFF;
      default: dur = 0;
    endcase
  endfunction

  // One rising edge of the model with the inputs present at that edge.
  task automatic model_step(input logic req, input logic lock, input logic [7:0] br);
    int pc, db, nxt;
    pc = (m_edge / PWM_DIV) % 256;
    db = m_duty;
    if ((m_edge % (256 * PWM_DIV)) == 0) m_duty = int'(br);
    m_edge++;
    nxt = m_phase;
    m_t++;
    case (m_phase)
      0: if (req) nxt = 1;
      1: if (!req) nxt = 6; else if (m_t >= dur(1)) nxt = 2;
      2: begin
        m_run = lock ? m_run + 1 : 0;
        if (!req) nxt = 5;
        else if (m_run >= T_VID) nxt = 3;
      end
      3: if (!req || !lock) begin
        nxt = 4;
        if (!lock) m_fault = 1;
      end
      4: if (m_t >= dur(4)) nxt = 5;
      5: if (m_t >= dur(5)) nxt = 6;
      6: if (m_t >= dur(6)) nxt = 0;
      default: nxt = 0;
    endcase
    if (nxt != m_phase) begin
      m_t = 0;
      m_run = 0;
      if (nxt == 1) m_fault = 0;
    end
    m_phase = nxt;
    m_pwm = ((nxt == 3) && (pc < db)) ? 1 : 0;
  endtask

  task automatic check_outputs();
    chk("state", 32'(state), 32'(m_phase));
    chk("vdd_en", 32'(panel_vdd_en), (m_phase >= 1 && m_phase <= 5) ? 1 : 0);
    chk("video_en", 32'(video_en), (m_phase >= 2 && m_phase <= 4) ? 1 : 0);
    chk("led_en", 32'(led_en), (m_phase == 3) ? 1 : 0);
    chk("ready", 32'(panel_ready), (m_phase == 3) ? 1 : 0);
    chk("fault", 32'(fault), 32'(m_fault));
    chk("led_pwm", 32'(led_pwm), 32'(m_pwm));
  endtask

  // One transaction: hold the given inputs for n cycles, checking each cycle.
  task automatic run(input logic req, input logic lock, input logic [7:0] br, input int n);
    seg++;
    $display("seg %0d: req=%0d lock=%0d bright=%0d cycles=%0d", seg, req, lock, br, n);
    for (int i = 0; i < n; i++) begin
      panel_req  = req;
      pll_locked = lock;
      brightness = br;
      @(posedge clk);
      model_step(req, lock, br);
      @(negedge clk);
      check_outputs();
    end
  endtask

  // Asynchronous reset between edges: outputs must clear without a clock.
  task automatic async_reset();
    seg++;
    $display("seg %0d: async reset in state %0d", seg, m_phase);
    #2;
    rst = 1'b1;
    #1;
    chk("rst_vdd", 32'(panel_vdd_en), 0);
    chk("rst_video", 32'(video_en), 0);
    chk("rst_led", 32'(led_en), 0);
    chk("rst_pwm", 32'(led_pwm), 0);
    chk("rst_ready", 32'(panel_ready), 0);
    chk("rst_fault", 32'(fault), 0);
    chk("rst_state", 32'(state), 0);
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check_outputs();
  endtask

  initial begin
    rst        = 1'b1;
    panel_req  = 1'b0;
    pll_locked = 1'b1;
    brightness = 8'd0;
    model_reset();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check_outputs();

    // Power-up with lock held, then PWM at 64, mid-period change to 192, then 0.
    run(1'b1, 1'b1, 8'd64, 600);
    run(1'b1, 1'b1, 8'd192, 300);
    run(1'b1, 1'b1, 8'd0, 300);
    // Power-down, request dropped in the backlight-on state.
    run(1'b0, 1'b1, 8'd0, 15);
    // Power-up with lock missing in link-up, then lock loss with the backlight on.
    run(1'b1, 1'b1, 8'd128, 5);
    run(1'b1, 1'b0, 8'd128, 10);
    run(1'b1, 1'b1, 8'd128, 12);
    run(1'b1, 1'b0, 8'd128, 3);
    run(1'b1, 1'b1, 8'd128, 30);
    run(1'b0, 1'b1, 8'd128, 15);
    // Abort two cycles into VDD ramp; re-assert during the off wait.
    run(1'b1, 1'b1, 8'd200, 2);
    run(1'b0, 1'b1, 8'd200, 2);
    run(1'b1, 1'b1, 8'd200, 12);
    run(1'b0, 1'b1, 8'd200, 20);
    // Reset mid-sequence while in link-up.
    run(1'b1, 1'b1, 8'd50, 6);
    async_reset();

    // Random segments.
    for (int s = 0; s < 150; s++) begin
      logic       rq, lk;
      logic [7:0] b;
      int         n;
      rq = ($urandom_range(0, 99) < 65);
      lk = ($urandom_range(0, 99) < 88);
      b  = 8'($urandom);
      n  = $urandom_range(1, 40);
      if ($urandom_range(0, 29) == 0) async_reset();
      else run(rq, lk, b, n);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
